serial_adder_core: RTL and testbench

Bit-serial adder stage sitting directly downstream of the two 4-bit PISO shift registers (operands A and B) in the serial-adder datapath. On `start` it drives the shared PISO shift enable for WIDTH cycles and consumes the LSB-first bit streams. It adds them with a single full-adder cell and a carry flip-flop, and collects sum bits in an internal SIPO. It then presents the parallel sum and carry-out with a one-cycle `done` pulse.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_fa_cell.sv | 36 +++
 rtl/serial_adder_core.sv | 122 ++++++++++++
 tb/tb_serial_adder_core.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder stage.
// Imported by the full-adder cell and the core.
package serial_adder_pkg;

   localparam int unsigned WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FLUSH,
      DONE
   } state_t;

   function automatic int unsigned cnt_w(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single full-adder cell with its carry flip-flop.
// Carry is loaded from cin on accept and advanced on each capture.
module serial_fa_cell
   import serial_adder_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic cin_i,
   input  logic en_i,
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_nxt_o
);

   logic carry_q;

   // Sum bit and next carry from the current operand bits.
   always_comb begin
      s_o     = a_i ^ b_i ^ carry_q;
      c_nxt_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);
   end

   // Carry register: load takes priority over capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q <= 1'b0;
      end else if (load_i) begin
         carry_q <= cin_i;
      end else if (en_i) begin
         carry_q <= c_nxt_o;
      end
   end

endmodule

// File: rtl/serial_adder_core.sv
// Bit-serial adder: drives the upstream PISO shift, adds LSB-first,
// collects the sum in a SIPO and pulses done with the parallel result.
module serial_adder_core
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cin,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             shift_en,
   output logic             busy,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done
);

   localparam int unsigned    CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sipo_q, sipo_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             load_c;
   logic             cap_c;
   logic             s_c;
   logic             c_nxt_c;

   serial_fa_cell u_fa (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_c),
      .cin_i   (cin),
      .en_i    (cap_c),
      .a_i     (a_bit),
      .b_i     (b_bit),
      .s_o     (s_c),
      .c_nxt_o (c_nxt_c)
   );

   // Next state, counter and control strobes.
   // Bits arrive one cycle after their shift edge, so the first
   // SHIFT cycle captures nothing and FLUSH takes the last bit.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_c   = 1'b0;
      cap_c    = 1'b0;
      shift_en = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               load_c  = 1'b1;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            cap_c    = (cnt_q != '0);
            if (cnt_q == CNT_LAST) begin
               state_d = FLUSH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FLUSH: begin
            cap_c   = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // SIPO shift on capture; result registers load on the final capture.
   always_comb begin
      sipo_d = sipo_q;
      sum_d  = sum_q;
      cout_d = cout_q;
      if (cap_c) begin
         sipo_d = {s_c, sipo_q[WIDTH-1:1]};
      end
      if (state_q == FLUSH) begin
         sum_d  = {s_c, sipo_q[WIDTH-1:1]};
         cout_d = c_nxt_c;
      end
   end

   // State, counter, SIPO and held result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sipo_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sipo_q  <= sipo_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_core.sv
// Self-checking bench for serial_adder_core with a PISO source model.
// Results are compared against plain A+B+cin arithmetic.
module tb_serial_adder_core;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         cin = 1'b0;
   logic         a_bit = 1'b0;
   logic         b_bit = 1'b0;
   logic         shift_en;
   logic         busy;
   logic [W-1:0] sum;
   logic         cout;
   logic         done;

   logic         ld = 1'b0;
   logic [W-1:0] lda = '0;
   logic [W-1:0] ldb = '0;
   logic [W-1:0] pa = '0;
   logic [W-1:0] pb = '0;

   int total = 0;
   int bad = 0;

   serial_adder_core #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cin      (cin),
      .a_bit    (a_bit),
      .b_bit    (b_bit),
      .shift_en (shift_en),
      .busy     (busy),
      .sum      (sum),
      .cout     (cout),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Upstream PISO pair: parallel load, then registered LSB-first output.
   always @(posedge clk) begin
      if (ld) begin
         pa <= lda;
         pb <= ldb;
      end else if (shift_en) begin
         a_bit <= pa[0];
         b_bit <= pb[0];
         pa    <= pa >> 1;
         pb    <= pb >> 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic c);
      int r;
      r = int'(a) + int'(b) + int'(c);
      return (W+1)'(r % (1 << (W+1)));
   endfunction

   // Called at a negedge while IDLE; returns at the negedge after done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input string tag);
      logic [W:0] exp;
      int ns;
      int dk;
      exp   = ref_add(a, b, c);
      lda   = a;
      ldb   = b;
      ld    = 1'b1;
      start = 1'b1;
      cin   = c;
      @(negedge clk);
      ld    = 1'b0;
      start = 1'b0;
      cin   = ~c;
      ns    = 0;
      dk    = -1;
      for (int k = 0; k < 12 && dk < 0; k++) begin
         if (shift_en) ns++;
         if (done) dk = k;
         else @(negedge clk);
      end
      chk({tag, " shifts"}, 32'(ns), 32'(W));
      chk({tag, " latency"}, 32'(dk), 32'(W + 1));
      chk({tag, " result"}, 32'({cout, sum}), 32'(exp));
      @(negedge clk);
      chk({tag, " idle"}, 32'(busy), 32'(0));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   q[$];
      logic [W:0]   held;
      int           last;
      int           ndone;
      int           spur;

      #12;
      chk("rst shift_en", 32'(shift_en), 32'(0));
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst done", 32'(done), 32'(0));
      chk("rst result", 32'({cout, sum}), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_op(4'b0101, 4'b0011, 1'b0, "d0101+0011");
      run_op(4'b1111, 4'b0001, 1'b0, "d1111+0001");
      run_op(4'b1111, 4'b1111, 1'b1, "d1111+1111c");
      run_op(4'b0000, 4'b0000, 1'b1, "d0000+0000c");

      // start held high: one addition per W+3 cycles, sum held between.
      start = 1'b1;
      last  = -1;
      ndone = 0;
      held  = '0;
      for (int t = 0; t < 60 && ndone < 4; t++) begin
         if (!busy) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            lda = ra;
            ldb = rb;
            cin = rc;
            ld  = 1'b1;
            q.push_back(ref_add(ra, rb, rc));
         end else begin
            ld = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            if (q.size() > 0) begin
               chk("hold result", 32'({cout, sum}), 32'(q.pop_front()));
            end
            if (last >= 0) chk("hold gap", 32'(t - last), 32'(W + 3));
            last = t;
            held = {cout, sum};
            ndone++;
         end else if (ndone > 0) begin
            chk("hold stable", 32'({cout, sum}), 32'(held));
         end
      end
      start = 1'b0;
      ld    = 1'b0;
      chk("hold count", 32'(ndone), 32'(4));
      @(negedge clk);
      @(negedge clk);

      // Make the held result nonzero, then abort an operation mid-shift.
      run_op(4'b1001, 4'b0100, 1'b0, "pre-rst");
      lda   = 4'b1010;
      ldb   = 4'b0101;
      ld    = 1'b1;
      start = 1'b1;
      @(negedge clk);
      ld    = 1'b0;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort shift_en", 32'(shift_en), 32'(0));
      chk("abort busy", 32'(busy), 32'(0));
      chk("abort done", 32'(done), 32'(0));
      chk("abort result", 32'({cout, sum}), 32'(0));
      @(negedge clk);
      rst  = 1'b0;
      spur = 0;
      for (int k = 0; k < 10; k++) begin
         if (done || busy) spur++;
         @(negedge clk);
      end
      chk("abort no done", 32'(spur), 32'(0));
      run_op(4'b0110, 4'b0111, 1'b0, "post-rst");

      for (int n = 0; n < 500; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(1, 0));
         run_op(ra, rb, rc, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
